// File: rtl/rcb_fpga_core.sv
// RCB I/O FPGA core: SPI-slave register file, synchronized board inputs, stop/ELO logic,
// fan PWM, sync pulse and heartbeat. Optional SPI watchdog enabled by defining SPI_WATCHDOG_EN.
module rcb_fpga_core #(
    parameter logic [15:0] VERSION     = 16'h0B10,
    parameter int unsigned SYNC_PERIOD = 100000,
    parameter int unsigned HB_HALF     = 50000000,
    parameter int unsigned PWM_DIV     = 16,
    parameter int unsigned WDOG_CYCLES = 10000000
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic        mosi,
    output logic        miso,
    input  logic [7:0]  btn_in,
    input  logic [15:0] drape_in,
    input  logic [23:0] wheel_sens_in,
    input  logic [11:0] wheel_sw_in,
    input  logic [3:0]  wheel_driver_do,
    input  logic [5:0]  aux_in,
    input  logic        teensy_estop_open_req,
    input  logic        miccb_estop_open_req,
    input  logic        teensy_open_elo_req,
    output logic [11:0] led_out,
    output logic [1:0]  drape_em_open,
    output logic [7:0]  wheel_driver_di,
    output logic        wheel_driver_rst,
    output logic        wheel_driver_abrt,
    output logic        diag_activation,
    output logic        estop_open,
    output logic        FPGA_WHEEL_STOP_ELO,
    output logic [7:0]  diagnostic_led,
    output logic        fan1_pwm,
    output logic        fan2_pwm,
    output logic        sync,
    output logic        pow
);

    localparam int unsigned SW = 76;
    // cs_n sits at the MSB and resets high so reset never looks like a frame start
    localparam logic [SW-1:0] SYNC_RST = {1'b1, {(SW-1){1'b0}}};

    logic [SW-1:0] async_in, sync1, sync2;
    logic        cs_s, sclk_s, mosi_s, teensy_s, miccb_s, elo_s;
    logic [5:0]  aux_s;
    logic [3:0]  do_s;
    logic [11:0] sw_s;
    logic [23:0] sens_s;
    logic [15:0] drape_s;
    logic [7:0]  btn_s;

    assign async_in = {cs_n, sclk, mosi, teensy_estop_open_req, miccb_estop_open_req,
                       teensy_open_elo_req, aux_in, wheel_driver_do, wheel_sw_in,
                       wheel_sens_in, drape_in, btn_in};
    assign {cs_s, sclk_s, mosi_s, teensy_s, miccb_s, elo_s, aux_s, do_s, sw_s,
            sens_s, drape_s, btn_s} = sync2;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= SYNC_RST;
            sync2 <= SYNC_RST;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
        end
    end

    logic sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_rise;
    logic [4:0]  bit_cnt;
    logic [23:0] rx_sr;
    logic [15:0] tx_sr, rdata;
    logic [6:0]  rd_addr;
    logic        frame_done, commit;
    logic        wdog_flag;

    logic [11:0] led_r;
    logic [9:0]  ctl_r;
    logic [3:0]  stop_r;
    logic [7:0]  dled_r;
    logic [15:0] fan_r, scratch_r;

    assign sclk_rise  = sclk_s & ~sclk_d & ~cs_s;
    assign sclk_fall  = ~sclk_s & sclk_d & ~cs_s;
    assign cs_rise    = cs_s & ~cs_d;
    assign frame_done = cs_rise && (bit_cnt == 5'd24);
    assign commit     = frame_done && rx_sr[23];
    // address is complete on the 8th rising edge, its last bit still on mosi_s
    assign rd_addr    = {rx_sr[5:0], mosi_s};

    always_comb begin
        rdata = 16'hDEAD;
        case (rd_addr)
            7'h00: rdata = VERSION;
            7'h01: rdata = {2'b00, aux_s, btn_s};
            7'h02: rdata = drape_s;
            7'h03: rdata = sens_s[15:0];
            7'h04: rdata = {8'h00, sens_s[23:16]};
            7'h05: rdata = {do_s, sw_s};
`ifdef SPI_WATCHDOG_EN
            7'h06: rdata = {15'd0, wdog_flag};
`endif
            7'h10: rdata = {4'h0, led_r};
            7'h11: rdata = {6'd0, ctl_r};
            7'h12: rdata = {12'h000, stop_r};
            7'h13: rdata = {8'h00, dled_r};
            7'h14: rdata = fan_r;
            7'h15: rdata = scratch_r;
            default: rdata = 16'hDEAD;
        endcase
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            sclk_d  <= 1'b0;
            cs_d    <= 1'b1;
            bit_cnt <= '0;
            rx_sr   <= '0;
            tx_sr   <= '0;
            miso    <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
            if (cs_s) begin
                bit_cnt <= '0;
                miso    <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx_sr <= {rx_sr[22:0], mosi_s};
                    if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'd7) tx_sr <= rdata;
                end
                if (sclk_fall && bit_cnt >= 5'd8) begin
                    miso  <= tx_sr[15];
                    tx_sr <= {tx_sr[14:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            led_r     <= '0;
            ctl_r     <= '0;
            stop_r    <= '0;
            dled_r    <= '0;
            fan_r     <= '0;
            scratch_r <= '0;
        end else if (commit) begin
            case (rx_sr[22:16])
                7'h10: led_r     <= rx_sr[11:0];
                7'h11: ctl_r     <= rx_sr[9:0];
                7'h12: stop_r    <= rx_sr[3:0];
                7'h13: dled_r    <= rx_sr[7:0];
                7'h14: fan_r     <= rx_sr[15:0];
                7'h15: scratch_r <= rx_sr[15:0];
                default: ;
            endcase
        end
    end

`ifdef SPI_WATCHDOG_EN
    logic [31:0] wdog_cnt;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt  <= '0;
            wdog_flag <= 1'b0;
        end else begin
            if (frame_done) wdog_cnt <= '0;
            else if (wdog_cnt != WDOG_CYCLES) wdog_cnt <= wdog_cnt + 32'd1;
            if (commit && rx_sr[22:16] == 7'h12) wdog_flag <= 1'b0;
            else if (wdog_cnt == WDOG_CYCLES) wdog_flag <= 1'b1;
        end
    end
`else
    assign wdog_flag = 1'b0;
`endif

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            estop_open          <= 1'b0;
            FPGA_WHEEL_STOP_ELO <= 1'b0;
        end else begin
            estop_open          <= stop_r[3] | teensy_s | miccb_s | wdog_flag;
            FPGA_WHEEL_STOP_ELO <= stop_r[3] | teensy_s | miccb_s | wdog_flag | elo_s;
        end
    end

    assign led_out           = led_r;
    assign wheel_driver_di   = ctl_r[7:0];
    assign wheel_driver_rst  = ctl_r[8];
    assign wheel_driver_abrt = ctl_r[9] | wdog_flag;
    assign diag_activation   = stop_r[2];
    assign drape_em_open     = estop_open ? 2'b00 : stop_r[1:0];
    assign diagnostic_led    = dled_r;

    logic [31:0] pwm_pre, sync_cnt, hb_cnt;
    logic [7:0]  pwm_cnt;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            pwm_pre  <= '0;
            pwm_cnt  <= '0;
            fan1_pwm <= 1'b0;
            fan2_pwm <= 1'b0;
            sync_cnt <= '0;
            sync     <= 1'b0;
            hb_cnt   <= '0;
            pow      <= 1'b0;
        end else begin
            if (pwm_pre == PWM_DIV - 1) begin
                pwm_pre <= '0;
                pwm_cnt <= (pwm_cnt == 8'd254) ? 8'd0 : pwm_cnt + 8'd1;
            end else begin
                pwm_pre <= pwm_pre + 32'd1;
            end
            fan1_pwm <= pwm_cnt < fan_r[7:0];
            fan2_pwm <= pwm_cnt < fan_r[15:8];

            if (sync_cnt == SYNC_PERIOD - 1) begin
                sync_cnt <= '0;
                sync     <= 1'b1;
            end else begin
                sync_cnt <= sync_cnt + 32'd1;
                sync     <= 1'b0;
            end

            if (hb_cnt == HB_HALF - 1) begin
                hb_cnt <= '0;
                pow    <= ~pow;
            end else begin
                hb_cnt <= hb_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_rcb_fpga_core.sv
// Scoreboard bench for rcb_fpga_core: a passive SPI monitor checks read frames against
// values queued by the stimulus from a register-map reference model.
module tb_rcb_fpga_core;

    localparam int unsigned SP   = 50;
    localparam int unsigned HB   = 30;
    localparam int unsigned PDIV = 2;
    localparam int T = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic [7:0]  btn_in = '0;
    logic [15:0] drape_in = '0;
    logic [23:0] wheel_sens_in = '0;
    logic [11:0] wheel_sw_in = '0;
    logic [3:0]  wheel_driver_do = '0;
    logic [5:0]  aux_in = '0;
    logic teensy = 1'b0, miccb = 1'b0, elo_req = 1'b0;
    logic miso, wheel_driver_rst, wheel_driver_abrt, diag_activation, estop_open, elo;
    logic fan1_pwm, fan2_pwm, sync, pow;
    logic [11:0] led_out;
    logic [1:0]  drape_em_open;
    logic [7:0]  wheel_driver_di, diagnostic_led;

    rcb_fpga_core #(.SYNC_PERIOD(SP), .HB_HALF(HB), .PWM_DIV(PDIV)) dut (
        .clk_100m(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
        .btn_in(btn_in), .drape_in(drape_in), .wheel_sens_in(wheel_sens_in),
        .wheel_sw_in(wheel_sw_in), .wheel_driver_do(wheel_driver_do), .aux_in(aux_in),
        .teensy_estop_open_req(teensy), .miccb_estop_open_req(miccb),
        .teensy_open_elo_req(elo_req), .led_out(led_out), .drape_em_open(drape_em_open),
        .wheel_driver_di(wheel_driver_di), .wheel_driver_rst(wheel_driver_rst),
        .wheel_driver_abrt(wheel_driver_abrt), .diag_activation(diag_activation),
        .estop_open(estop_open), .FPGA_WHEEL_STOP_ELO(elo), .diagnostic_led(diagnostic_led),
        .fan1_pwm(fan1_pwm), .fan2_pwm(fan2_pwm), .sync(sync), .pow(pow)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;
    logic [15:0] exp_q[$];
    logic [15:0] m[6];  // RW registers 0x10..0x15, stored masked to their defined bits
    int unsigned cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] rw_mask(input logic [6:0] a);
        case (a)
            7'h10: return 16'h0FFF;
            7'h11: return 16'h03FF;
            7'h12: return 16'h000F;
            7'h13: return 16'h00FF;
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [15:0] rd_model(input logic [6:0] a);
        if (a >= 7'h10 && a <= 7'h15) return m[a - 7'h10];
        case (a)
            7'h00: return 16'h0B10;
            7'h01: return {2'b00, aux_in, btn_in};
            7'h02: return drape_in;
            7'h03: return wheel_sens_in[15:0];
            7'h04: return {8'h00, wheel_sens_in[23:16]};
            7'h05: return {wheel_driver_do, wheel_sw_in};
            default: return 16'hDEAD;
        endcase
    endfunction

    task automatic check_outputs();
        logic stop;
        stop = m[2][3] | teensy | miccb;
        check("led_out", led_out, m[0][11:0]);
        check("wheel_di", wheel_driver_di, m[1][7:0]);
        check("wheel_rst", wheel_driver_rst, m[1][8]);
        check("wheel_abrt", wheel_driver_abrt, m[1][9]);
        check("diag_act", diag_activation, m[2][2]);
        check("estop_open", estop_open, stop);
        check("elo", elo, stop | elo_req);
        check("drape_em", drape_em_open, stop ? 2'b00 : m[2][1:0]);
        check("diag_led", diagnostic_led, m[3][7:0]);
    endtask

    // Sends nbits of {wr,addr,data} MSB first; rst_at >= 0 pulses reset before that bit.
    task automatic frame(input logic wr, input logic [6:0] addr, input logic [15:0] data,
                         input int nbits, input int rst_at);
        logic [23:0] w;
        w = {wr, addr, data};
        if (!wr && nbits == 24 && rst_at < 0) exp_q.push_back(rd_model(addr));
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                #30 rst_n = 1'b1;
                #70;
            end
            mosi = (i < 24) ? w[23 - i] : 1'b0;
            #(T) sclk = 1'b1;
            #(T) sclk = 1'b0;
        end
        #(T) cs_n = 1'b1;
        mosi = 1'b0;
        if (rst_at >= 0 && rst_at < nbits) begin
            for (int k = 0; k < 6; k++) m[k] = '0;
        end else if (wr && nbits == 24 && addr >= 7'h10 && addr <= 7'h15) begin
            m[addr - 7'h10] = data & rw_mask(addr);
        end
        #(4 * T);
        check("miso_idle", miso, 1'b0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // sync/heartbeat timing against cycles elapsed since reset release
    initial forever begin
        @(negedge clk);
        #1;
        check("sync", sync, (cyc > 0 && cyc % SP == 0) ? 1'b1 : 1'b0);
        check("pow", pow, ((cyc / HB) % 2 == 1) ? 1'b1 : 1'b0);
    end

    // passive SPI monitor: compares every complete 24-bit read against the scoreboard
    initial forever begin
        logic [31:0] mo, mi;
        int n;
        @(negedge cs_n);
        n = 0;
        mo = '0;
        mi = '0;
        forever begin
            @(posedge sclk or posedge cs_n);
            if (cs_n) break;
            mo = {mo[30:0], mosi};
            mi = {mi[30:0], miso};
            n++;
        end
        if (n == 24 && mo[23] == 1'b0) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL rd_queue: read of %0h with nothing expected", mo[22:16]);
            end else begin
                check($sformatf("rd_%02h", mo[22:16]), mi[15:0], exp_q.pop_front());
            end
        end
    end

    initial begin
        int unsigned hi1, hi2, w;
        logic [6:0] pool[14];
        pool = '{7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06,
                 7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15, 7'h20};
        for (int k = 0; k < 6; k++) m[k] = '0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs();
        check("fan1_rst", fan1_pwm, 1'b0);
        check("fan2_rst", fan2_pwm, 1'b0);
        check("miso_rst", miso, 1'b0);

        frame(1'b0, 7'h00, 16'h0, 24, -1);
        frame(1'b0, 7'h20, 16'h0, 24, -1);
        frame(1'b1, 7'h10, 16'h0A5A, 24, -1);
        check("led_a5a", led_out, 12'hA5A);
        frame(1'b0, 7'h10, 16'h0, 24, -1);

        frame(1'b1, 7'h12, 16'h0003, 24, -1);
        check("drape_open", drape_em_open, 2'b11);
        miccb = 1'b1;
        repeat (6) @(negedge clk);
        check("estop_miccb", estop_open, 1'b1);
        check("elo_miccb", elo, 1'b1);
        check("drape_forced", drape_em_open, 2'b00);
        miccb = 1'b0;
        repeat (6) @(negedge clk);
        check("drape_release", drape_em_open, 2'b11);
        check("estop_release", estop_open, 1'b0);

        frame(1'b1, 7'h13, 16'h00FF, 20, -1);
        check("short_frame", diagnostic_led, 8'h00);
        frame(1'b1, 7'h13, 16'h00FF, 25, -1);
        check("long_frame", diagnostic_led, 8'h00);

        frame(1'b1, 7'h14, 16'hFF40, 24, -1);
        hi1 = 0;
        hi2 = 0;
        repeat (255 * PDIV) begin
            @(negedge clk);
            hi1 += fan1_pwm;
            hi2 += fan2_pwm;
        end
        check("fan1_duty", hi1, 64 * PDIV);
        check("fan2_duty", hi2, 255 * PDIV);

        frame(1'b1, 7'h15, 16'h1234, 24, -1);
        frame(1'b0, 7'h15, 16'h0, 24, -1);
        frame(1'b1, 7'h15, 16'hBEEF, 24, 12);
        frame(1'b0, 7'h15, 16'h0, 24, -1);
        check_outputs();

        for (int t = 0; t < 40; t++) begin
            btn_in = 8'($urandom);
            drape_in = 16'($urandom);
            wheel_sens_in = 24'($urandom);
            wheel_sw_in = 12'($urandom);
            wheel_driver_do = 4'($urandom);
            aux_in = 6'($urandom);
            teensy = ($urandom_range(0, 3) == 0);
            miccb = ($urandom_range(0, 3) == 0);
            elo_req = ($urandom_range(0, 3) == 0);
            repeat (5) @(negedge clk);
            w = ($urandom_range(0, 9) < 8) ? 24 : $urandom_range(1, 30);
            frame(1'($urandom), pool[$urandom_range(0, 13)], 16'($urandom), int'(w), -1);
            check_outputs();
        end

        for (int k = 0; k < 1000 && exp_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
